// File: rtl/spart_host_driver.sv
// Host-side bus master for the mini SPART: programs the baud divisor, then echoes RX to TX.
// Optional macro SPART_DRV_UPCASE_EN converts lower-case echoes to upper case.
module spart_host_driver #(
    parameter logic [15:0] DB_4800  = 16'h0515,
    parameter logic [15:0] DB_9600  = 16'h028A,
    parameter logic [15:0] DB_19200 = 16'h0145,
    parameter logic [15:0] DB_38400 = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus_out,
    input  logic [7:0] databus_in,
    output logic [7:0] last_char,
    output logic [7:0] echo_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_LO,
        S_INIT_HI,
        S_POLL_RX,
        S_READ_RX,
        S_POLL_TX,
        S_WRITE_TX
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_br_cfg_q;
    logic [7:0]  r_char;
    logic [7:0]  r_last_char;
    logic [7:0]  r_echo_count;
    logic [15:0] w_div;
    logic [7:0]  w_tx_char;

    always_comb begin
        w_div = DB_4800;
        case (r_br_cfg_q)
            2'b00:   w_div = DB_4800;
            2'b01:   w_div = DB_9600;
            2'b10:   w_div = DB_19200;
            default: w_div = DB_38400;
        endcase
    end

`ifdef SPART_DRV_UPCASE_EN
    // 'a'..'z' differ from 'A'..'Z' only in bit 5
    assign w_tx_char = (r_char >= 8'h61 && r_char <= 8'h7A) ?
                       (r_char & 8'hDF) : r_char;
`else
    assign w_tx_char = r_char;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_br_cfg_q   <= br_cfg;
            r_char       <= 8'h00;
            r_last_char  <= 8'h00;
            r_echo_count <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_next == S_INIT_LO && r_state != S_INIT_LO)
                r_br_cfg_q <= br_cfg;
            if (r_state == S_READ_RX) begin
                r_char      <= databus_in;
                r_last_char <= databus_in;
            end
            if (r_state == S_WRITE_TX)
                r_echo_count <= r_echo_count + 8'h01;
        end
    end

    always_comb begin
        w_next      = r_state;
        iocs        = 1'b1;
        iorw        = 1'b1;
        ioaddr      = 2'b00;
        databus_out = 8'h00;
        unique case (r_state)
            S_IDLE: begin
                iocs   = 1'b0;
                w_next = S_INIT_LO;
            end
            S_INIT_LO: begin
                iorw        = 1'b0;
                ioaddr      = 2'b10;
                databus_out = w_div[7:0];
                w_next      = S_INIT_HI;
            end
            S_INIT_HI: begin
                iorw        = 1'b0;
                ioaddr      = 2'b11;
                databus_out = w_div[15:8];
                w_next      = S_POLL_RX;
            end
            S_POLL_RX: begin
                ioaddr = 2'b01;
                // baud changes are only honoured between echoes
                if (br_cfg != r_br_cfg_q)
                    w_next = S_INIT_LO;
                else if (databus_in[0])
                    w_next = S_READ_RX;
            end
            S_READ_RX: begin
                ioaddr = 2'b00;
                w_next = S_POLL_TX;
            end
            S_POLL_TX: begin
                ioaddr = 2'b01;
                if (databus_in[1])
                    w_next = S_WRITE_TX;
            end
            S_WRITE_TX: begin
                iorw        = 1'b0;
                ioaddr      = 2'b00;
                databus_out = w_tx_char;
                w_next      = S_POLL_RX;
            end
            default: begin
                iocs   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign last_char  = r_last_char;
    assign echo_count = r_echo_count;

endmodule

// File: tb/tb_spart_host_driver.sv
// Self-checking bench for spart_host_driver: directed bring-up/echo cases,
// then randomized SPART status/data against a transaction-level echo model.
module tb_spart_host_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus_out;
    logic [7:0] databus_in;
    logic [7:0] last_char;
    logic [7:0] echo_count;

    logic [7:0] stat;
    logic [7:0] rx;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic [7:0] last_stat;
    int         cnt;
    bit         reinit_pending;

    spart_host_driver dut (
        .clk         (clk),
        .rst         (rst),
        .br_cfg      (br_cfg),
        .iocs        (iocs),
        .iorw        (iorw),
        .ioaddr      (ioaddr),
        .databus_out (databus_out),
        .databus_in  (databus_in),
        .last_char   (last_char),
        .echo_count  (echo_count)
    );

    always #5 clk = ~clk;

    // SPART side: status at 01, RX buffer at 00, valid in the read cycle
    assign databus_in = (iocs && iorw) ?
                        ((ioaddr == 2'b01) ? stat : rx) : 8'h00;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] div_of(input logic [1:0] b);
        case (b)
            2'b00:   return 16'h0515;
            2'b01:   return 16'h028A;
            2'b10:   return 16'h0145;
            default: return 16'h00A2;
        endcase
    endfunction

    function automatic logic [7:0] tx_of(input logic [7:0] c);
`ifdef SPART_DRV_UPCASE_EN
        if (c >= 8'h61 && c <= 8'h7A)
            return c - 8'h20;
`endif
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input string tag, input logic cs, input logic rw,
                       input logic [1:0] a, input logic [7:0] d);
        check(tag, {cs, iorw & cs | rw & ~cs, ioaddr, databus_out},
              {cs, rw, a, d});
    endtask

    // transaction-level echo model: every RX read must be followed by
    // exactly one TX write of the same (optionally upcased) byte
    task automatic observe;
        logic [15:0] d;
        logic [7:0]  c;
        d = div_of(br_cfg);
        if (reinit_pending) begin
            check("reinit", {iocs, iorw, ioaddr}, 4'b1010);
            reinit_pending = 0;
        end
        if (iocs) begin
            case ({iorw, ioaddr})
                3'b101: last_stat = stat;
                3'b100: begin
                    q.push_back(rx);
                    check("rx_depth", q.size(), 1);
                end
                3'b000: begin
                    check("tx_pend", q.size(), 1);
                    c = (q.size() > 0) ? q.pop_front() : 8'h00;
                    check("tx_data", databus_out, tx_of(c));
                    check("tx_last", last_char, c);
                    check("tx_tbr", last_stat[1], 1'b1);
                    check("tx_cnt", echo_count, cnt[7:0]);
                    cnt++;
                    last_stat = 8'h00;
                end
                3'b010: check("div_lo", databus_out, d[7:0]);
                3'b011: check("div_hi", databus_out, d[15:8]);
                default: check("bad_acc", {iorw, ioaddr}, 3'b101);
            endcase
        end
    endtask

    initial begin
        rst    = 1'b1;
        br_cfg = 2'b01;
        stat   = 8'h00;
        rx     = 8'h00;
        cnt    = 0;
        last_stat      = 8'h00;
        reinit_pending = 0;

        repeat (3) begin
            tick;
            check("rst_cs", iocs, 1'b0);
            check("rst_cnt", echo_count, 8'h00);
            check("rst_last", last_char, 8'h00);
        end
        rst = 1'b0;
        check("idle_cs", iocs, 1'b0);
        check("idle_bus", {iorw, ioaddr, databus_out}, {1'b1, 2'b00, 8'h00});

        tick; bus("init_lo", 1, 0, 2'b10, 8'h8A);
        tick; bus("init_hi", 1, 0, 2'b11, 8'h02);
        repeat (3) begin
            tick; bus("poll_rx", 1, 1, 2'b01, 8'h00);
        end

        stat = 8'h03; rx = 8'h41;
        tick; bus("rd_rx", 1, 1, 2'b00, 8'h00);
        tick; bus("poll_tx", 1, 1, 2'b01, 8'h00);
        check("last_41", last_char, 8'h41);
        tick; bus("wr_41", 1, 0, 2'b00, 8'h41);
        stat = 8'h00;
        tick; bus("back_rx", 1, 1, 2'b01, 8'h00);
        check("cnt_1", echo_count, 8'h01);

        stat = 8'h01; rx = 8'h5A;
        tick; bus("rd_5a", 1, 1, 2'b00, 8'h00);
        stat = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick; bus("tx_wait", 1, 1, 2'b01, 8'h00);
        end
        tick; bus("tx_wait6", 1, 1, 2'b01, 8'h00);
        stat = 8'h02;
        tick; bus("wr_5a", 1, 0, 2'b00, 8'h5A);
        stat = 8'h00;
        tick; check("cnt_2", echo_count, 8'h02);

        br_cfg = 2'b11;
        tick; bus("re_lo", 1, 0, 2'b10, 8'hA2);
        tick; bus("re_hi", 1, 0, 2'b11, 8'h00);
        tick; bus("re_poll", 1, 1, 2'b01, 8'h00);

        stat = 8'h01; rx = 8'h55;
        tick;
        stat = 8'h00;
        tick;
        br_cfg = 2'b10;
        tick; bus("hold_tx", 1, 1, 2'b01, 8'h00);
        stat = 8'h02;
        tick; bus("wr_55", 1, 0, 2'b00, 8'h55);
        stat = 8'h00;
        tick; bus("poll_chg", 1, 1, 2'b01, 8'h00);
        tick; bus("re2_lo", 1, 0, 2'b10, 8'h45);
        tick; bus("re2_hi", 1, 0, 2'b11, 8'h01);
        tick; bus("re2_poll", 1, 1, 2'b01, 8'h00);

        stat = 8'h03; rx = 8'h61;
        tick; tick; tick;
        bus("wr_61", 1, 0, 2'b00, tx_of(8'h61));
        check("last_61", last_char, 8'h61);
        stat = 8'h00;
        tick; check("cnt_4", echo_count, 8'h04);

        stat = 8'h01; rx = 8'h77;
        tick;
        rst = 1'b1;
        tick;
        check("mid_cs", iocs, 1'b0);
        check("mid_cnt", echo_count, 8'h00);
        check("mid_last", last_char, 8'h00);
        rst  = 1'b0;
        stat = 8'h00;

        for (int i = 0; i < 3000; i++) begin
            stat = {$urandom_range(0, 63), 2'b00};
            stat[0] = ($urandom_range(0, 9) < 3);
            stat[1] = ($urandom_range(0, 1) == 1);
            rx = $urandom_range(0, 3) == 0 ?
                 8'($urandom_range(8'h61, 8'h7A)) : 8'($urandom);
            observe;
            if (!reinit_pending && iocs && iorw && ioaddr == 2'b01 &&
                q.size() == 0 && $urandom_range(0, 39) == 0) begin
                br_cfg = br_cfg + 2'b01;
                reinit_pending = 1;
            end
            tick;
        end

        begin
            int target;
            target = ((cnt >> 8) + 1) << 8;
            stat = 8'h03;
            for (int i = 0; i < 1300 && cnt < target; i++) begin
                rx = 8'($urandom);
                observe;
                tick;
            end
            check("wrap_reach", cnt, target);
            check("wrap_cnt", echo_count, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
